mem_responder_4c: RTL and testbench
===================================

Name: mem_responder_4c

Overview:
Multi-cycle data-memory responder for the WISC pipeline. It replaces the single-cycle data memory behind the cache-fill / MEM-stage initiator. The block takes word requests over a valid/ready handshake and returns read data a fixed latency later, in order, with output backpressure. It also supports 8-word line bursts for cache fills; writes are posted and return no response.

Parameters:
DWIDTH, 16, data word width
AWIDTH, 16, byte address width (bit 0 ignored, word-aligned)
LATENCY, 4, cycles from request acceptance to response beat (>=2)
BURST_LEN, 8, words per line burst (16-byte line)
INIT_FILE, "", hex file loaded into the array at time zero if non-empty

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
req_valid  in  1  initiator presents a request
req_ready  out  1  responder accepts the request this cycle
req_wr  in  1  1=write, 0=read
req_burst  in  1  1=line read burst of BURST_LEN words (ignored when req_wr=1)
req_addr  in  AWIDTH  byte address
req_wdata  in  DWIDTH  write data
resp_valid  out  1  response beat valid
resp_ready  in  1  initiator accepts the beat
resp_data  out  DWIDTH  read data
resp_addr  out  AWIDTH  byte address of this beat (bit 0 = 0)
resp_last  out  1  final beat of a burst, or a single read
busy  out  1  burst issuing or any read in flight

Behaviour:
- Reset (rst=0, async): resp_valid=0, resp_last=0, resp_data=0, resp_addr=0, busy=0, req_ready=0 while rst=0. All pipeline valids clear, FSM to IDLE. Array contents are unaffected.
- A request is accepted on a rising edge with req_valid & req_ready. Data is word-indexed by req_addr[AWIDTH-1:1].
- Write: the array updates on the acceptance edge. No response beat. A read accepted on the next cycle returns the new value.
- Single read: the array is read at acceptance; data, address and last=1 enter the delay pipe. resp_valid rises exactly LATENCY cycles after the acceptance edge when there is no stall. Up to LATENCY reads are in flight, one accepted per cycle. Responses are in acceptance order.
- Read data is captured at acceptance, so later writes never alter an in-flight read.
- Stall: resp_valid & ~resp_ready holds the whole pipe, including the output, and forces req_ready=0. resp_data/resp_addr/resp_last stay stable until the beat is taken.
- FSM states:
  - IDLE: req_ready = ~stall.
  - BURST: req_ready=0. Entered on acceptance of a read with req_burst=1.
    - Base = req_addr with the low 4 bits cleared (line-aligned).
    - One internal read is issued per unstalled cycle, at offsets 0,2,...,14.
    - Beat k is issued on the k-th cycle, counting the acceptance cycle as beat 0.
    - resp_last=1 only on offset 14.
    - Returns to IDLE after the issue of beat 7.
- Burst beats are consecutive at the output, one per cycle when resp_ready=1. The first beat arrives LATENCY cycles after acceptance.
- The line is aligned, so there is no address wrap within a burst. The top line 0xFFF0-0xFFFE is legal.
- Burst counter: 3 bits. Saturation/wrap is unreachable because the FSM exits at count 7.
- busy = (state==BURST) | any pipe stage valid.
- Reset mid-burst or with reads in flight discards all pending beats. No partial beat is emitted after rst deasserts.
- req_burst=1 with req_wr=1 is a single write.
- req_addr[0]=1 is treated as word address req_addr[AWIDTH-1:1].

Decomposition:
- Package mem_resp_pkg holds:
  - LATENCY and BURST_LEN defaults
  - LINE_OFFSET_BITS=4
  - FSM state encoding: IDLE=1'b0, BURST=1'b1
  - beat record field widths: data, addr, last
- Sub-module resp_delay_pipe (parameters LATENCY, payload width): a stallable valid/payload shift register with a global hold. Used once for the read path.

Test Plan:
- Write 0x1234 to 0x0010, then read 0x0010 the next cycle, resp_ready=1 → resp_valid 4 cycles after the read acceptance; resp_data=0x1234, resp_addr=0x0010, resp_last=1.
- Back-to-back reads of 0x0000, 0x0002, 0x0004 (preloaded 0xA, 0xB, 0xC) → three consecutive beats in order; first beat at acceptance+4; req_ready stays 1.
- Burst read at 0x0026 → req_ready=0 for 7 cycles; 8 beats with resp_addr 0x0020..0x002E; resp_last=1 only on 0x002E; busy falls the cycle after the last beat is taken.
- Hold resp_ready=0 for 3 cycles while the first burst beat is presented → the beat is held unchanged; req_ready=0; no beats lost or duplicated after release.
- Read 0x0040 (old 0x5555), then write 0x0040=0x7777 the next cycle → the read returns 0x5555; a subsequent read returns 0x7777.
- Assert rst=0 mid-burst after beat 3 is issued → outputs go to 0 immediately; no beats after rst=1; the next single read completes normally at latency 4.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared defaults, FSM encoding and beat field widths for the data-memory responder
package mem_resp_pkg;
    localparam int LATENCY_DEF      = 4;
    localparam int BURST_LEN_DEF    = 8;
    localparam int LINE_OFFSET_BITS = 4;
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BURST = 1'b1;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int LAST_W = 1;
endpackage

// File: rtl/resp_delay_pipe.sv
// resp_delay_pipe: stallable valid/payload shift register; a beat enters on one edge and
// reaches the output LATENCY edges later, the whole chain freezing while i_hold is high
module resp_delay_pipe #(
    parameter int LATENCY = 4,
    parameter int PW      = 33
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          i_hold,
    input  logic          i_valid,
    input  logic [PW-1:0] i_data,
    output logic          o_valid,
    output logic [PW-1:0] o_data,
    output logic          o_any
);
    logic [LATENCY:0]         r_valid;
    logic [LATENCY:0][PW-1:0] r_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
            r_data  <= '0;
        end else if (!i_hold) begin
            r_valid <= {r_valid[LATENCY-1:0], i_valid};
            r_data  <= {r_data[LATENCY-1:0], i_data};
        end
    end

    assign o_valid = r_valid[LATENCY];
    assign o_data  = r_data[LATENCY];
    assign o_any   = |r_valid;
endmodule

// File: rtl/mem_responder_4c.sv
// mem_responder_4c: fixed-latency in-order data-memory responder with posted writes,
// 8-word line bursts for cache fills and whole-pipe output backpressure
module mem_responder_4c
    import mem_resp_pkg::*;
#(
    parameter int DWIDTH    = DATA_W,
    parameter int AWIDTH    = ADDR_W,
    parameter int LATENCY   = LATENCY_DEF,
    parameter int BURST_LEN = BURST_LEN_DEF
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic              req_burst,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DWIDTH-1:0] resp_data,
    output logic [AWIDTH-1:0] resp_addr,
    output logic              resp_last,
    output logic              busy
);
    localparam int CW = LINE_OFFSET_BITS - 1;
    localparam int PW = DWIDTH + AWIDTH + LAST_W;
    localparam logic [CW-1:0] LAST_IDX = CW'(BURST_LEN - 1);

    logic [DWIDTH-1:0]                  r_mem [0:(1<<(AWIDTH-1))-1];
    logic [0:0]                         r_state;
    logic [CW-1:0]                      r_cnt;
    logic [AWIDTH-LINE_OFFSET_BITS-1:0] r_base;
    logic              w_stall, w_acc, w_issue, w_first_burst, w_iss_last, w_any;
    logic [AWIDTH-1:0] w_word_addr, w_iss_addr;
    logic [DWIDTH-1:0] w_iss_data;
    logic [PW-1:0]     w_pipe_out;

    assign w_stall       = resp_valid & ~resp_ready;
    assign req_ready     = rst & ~w_stall & (r_state == IDLE);
    assign w_acc         = req_valid & req_ready;
    assign w_first_burst = w_acc & ~req_wr & req_burst;
    assign w_issue       = (w_acc & ~req_wr) | ((r_state == BURST) & ~w_stall);
    assign w_word_addr   = req_addr & ~AWIDTH'(1);
    // Beat 0 of a burst is issued straight from the request; later beats come from the latched line base
    assign w_iss_addr    = (r_state == BURST) ? {r_base, r_cnt, 1'b0} :
                           req_burst ? {w_word_addr[AWIDTH-1:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}} :
                           w_word_addr;
    assign w_iss_last    = (r_state == BURST) ? (r_cnt == LAST_IDX) : ~req_burst;
    assign w_iss_data    = r_mem[w_iss_addr[AWIDTH-1:1]];
    assign busy          = (r_state == BURST) | w_any;

    always_ff @(posedge clk) begin
        if (w_acc & req_wr) r_mem[w_word_addr[AWIDTH-1:1]] <= req_wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_base  <= '0;
        end else if (r_state == IDLE) begin
            if (w_first_burst) begin
                r_state <= BURST;
                r_cnt   <= CW'(1);
                r_base  <= w_word_addr[AWIDTH-1:LINE_OFFSET_BITS];
            end
        end else if (!w_stall) begin
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == LAST_IDX) r_state <= IDLE;
        end
    end

    resp_delay_pipe #(.LATENCY(LATENCY), .PW(PW)) u_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_hold  (w_stall),
        .i_valid (w_issue),
        .i_data  ({w_iss_data, w_iss_addr, w_iss_last}),
        .o_valid (resp_valid),
        .o_data  (w_pipe_out),
        .o_any   (w_any)
    );

    assign {resp_data, resp_addr, resp_last} = w_pipe_out;
endmodule

// File: tb/tb_mem_responder_4c.sv
// tb_mem_responder_4c: directed and random stimulus against a word-array plus expected-beat-queue model
module tb_mem_responder_4c;
    logic        clk = 0, rst = 1;
    logic        req_valid = 0, req_wr = 0, req_burst = 0, resp_ready = 0;
    logic [15:0] req_addr = 0, req_wdata = 0;
    logic        req_ready, resp_valid, resp_last, busy;
    logic [15:0] resp_data, resp_addr;

    mem_responder_4c dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_burst(req_burst), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_data(resp_data), .resp_addr(resp_addr), .resp_last(resp_last),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [15:0] d; logic [15:0] a; logic l;} beat_t;
    beat_t       expq[$];
    logic [15:0] mem_m [0:32767];
    int          took_cyc[$];
    int          checks = 0, errors = 0, cycle = 0, acc_cycle = 0, taken = 0;
    logic        s_acc = 0, s_stall = 0, prev_stall = 0;
    logic [33:0] prev_vec = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int tk(input int k);
        return took_cyc.size() > k ? took_cyc[k] : -1;
    endfunction

    // One clock: sample mid-cycle, score any handshake, then advance past the edge
    task automatic cyc();
        logic [33:0] cur;
        logic [15:0] base;
        beat_t e;
        #3;
        cur = {resp_valid, resp_last, resp_addr, resp_data};
        if (prev_stall) chk("stall_hold", 64'(cur), 64'(prev_vec));
        s_stall = resp_valid & ~resp_ready;
        if (s_stall) chk("ready_in_stall", 64'(req_ready), 0);
        prev_stall = s_stall;
        prev_vec = cur;
        s_acc = req_valid & req_ready;
        if (resp_valid & resp_ready) begin
            chk("beat_expected", 64'(expq.size() != 0), 1);
            if (expq.size() != 0) begin
                e = expq.pop_front();
                chk("beat_data", 64'(resp_data), 64'(e.d));
                chk("beat_addr", 64'(resp_addr), 64'(e.a));
                chk("beat_last", 64'(resp_last), 64'(e.l));
            end
            took_cyc.push_back(cycle);
            taken++;
        end
        if (s_acc) begin
            acc_cycle = cycle + 1;
            if (req_wr) mem_m[req_addr[15:1]] = req_wdata;
            else if (req_burst) begin
                base = req_addr & 16'hFFF0;
                for (int k = 0; k < 8; k++)
                    expq.push_back(beat_t'{d: mem_m[15'((base >> 1) + k)], a: base + 16'(2 * k), l: (k == 7)});
            end else
                expq.push_back(beat_t'{d: mem_m[req_addr[15:1]], a: req_addr & 16'hFFFE, l: 1'b1});
        end
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic put(input logic wr, input logic burst, input logic [15:0] a, input logic [15:0] d, output int tries);
        req_valid = 1; req_wr = wr; req_burst = burst; req_addr = a; req_wdata = d;
        tries = 0;
        cyc();
        while (!s_acc && tries < 30) begin
            tries++;
            cyc();
        end
        if (!s_acc) chk("accept_timeout", 64'(s_acc), 1);
        req_valid = 0;
    endtask

    task automatic drain();
        req_valid = 0;
        resp_ready = 1;
        for (int i = 0; i < 200 && expq.size() != 0; i++) cyc();
        chk("drained", 64'(expq.size()), 0);
    endtask

    initial begin
        int t, a, n0;
        logic bb;
        #1 rst = 0;
        #1;
        chk("rst_resp_valid", 64'(resp_valid), 0);
        chk("rst_resp_last", 64'(resp_last), 0);
        chk("rst_resp_data", 64'(resp_data), 0);
        chk("rst_resp_addr", 64'(resp_addr), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_req_ready", 64'(req_ready), 0);
        @(posedge clk);
        #1 rst = 1;
        resp_ready = 1;
        for (int i = 0; i < 64; i++)
            put(1, 0, 16'(2 * i), i == 0 ? 16'hA : i == 1 ? 16'hB : i == 2 ? 16'hC :
                i == 32 ? 16'h5555 : 16'($urandom), t);

        // write then read-after-write, latency 4
        put(1, 0, 16'h0010, 16'h1234, t);
        took_cyc.delete();
        put(0, 0, 16'h0010, 0, t);
        chk("t1_ready", 64'(t), 0);
        a = acc_cycle;
        for (int i = 0; i < 20 && took_cyc.size() == 0; i++) cyc();
        chk("t1_latency", 64'(tk(0) - a), 4);

        // back-to-back singles
        took_cyc.delete();
        put(0, 0, 16'h0000, 0, t); chk("t2_ready0", 64'(t), 0);
        a = acc_cycle;
        put(0, 0, 16'h0002, 0, t); chk("t2_ready1", 64'(t), 0);
        put(0, 0, 16'h0004, 0, t); chk("t2_ready2", 64'(t), 0);
        for (int i = 0; i < 20 && took_cyc.size() < 3; i++) cyc();
        for (int k = 0; k < 3; k++) chk("t2_beat_cycle", 64'(tk(k) - a), 64'(4 + k));

        // burst at an unaligned address, write waiting behind it
        took_cyc.delete();
        put(0, 1, 16'h0026, 0, t);
        a = acc_cycle;
        put(1, 0, 16'h0100, 16'hBEEF, t);
        chk("t3_ready_low_cycles", 64'(t), 7);
        bb = 0;
        for (int i = 0; i < 40 && took_cyc.size() < 8; i++) begin
            if (took_cyc.size() == 7) bb = busy;
            cyc();
        end
        for (int k = 0; k < 8; k++) chk("t3_beat_cycle", 64'(tk(k) - a), 64'(4 + k));
        chk("t3_busy_before_last", 64'(bb), 1);
        chk("t3_busy_after_last", 64'(busy), 0);

        // stall on the first burst beat
        n0 = taken;
        put(0, 1, 16'h0020, 0, t);
        resp_ready = 0;
        for (int i = 0; i < 10 && !resp_valid; i++) cyc();
        req_valid = 1; req_wr = 1; req_burst = 0; req_addr = 16'h0102; req_wdata = 16'h0F0F;
        repeat (3) begin
            chk("t4_stall_addr", 64'(resp_addr), 16'h0020);
            cyc();
        end
        drain();
        chk("t4_beat_count", 64'(taken - n0), 8);

        // in-flight read keeps its captured data
        put(0, 0, 16'h0040, 0, t);
        put(1, 0, 16'h0040, 16'h7777, t);
        put(0, 0, 16'h0040, 0, t);
        drain();

        // reset after beat 3 of a burst is issued
        put(0, 1, 16'h0020, 0, t);
        repeat (3) cyc();
        rst = 0;
        #1;
        chk("t6_resp_valid", 64'(resp_valid), 0);
        chk("t6_resp_data", 64'(resp_data), 0);
        chk("t6_resp_addr", 64'(resp_addr), 0);
        chk("t6_resp_last", 64'(resp_last), 0);
        chk("t6_busy", 64'(busy), 0);
        chk("t6_req_ready", 64'(req_ready), 0);
        expq.delete();
        prev_stall = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1;
        repeat (8) begin
            cyc();
            chk("t6_quiet", 64'(resp_valid), 0);
        end
        took_cyc.delete();
        put(0, 0, 16'h0010, 0, t);
        a = acc_cycle;
        for (int i = 0; i < 20 && took_cyc.size() == 0; i++) cyc();
        chk("t6_latency", 64'(tk(0) - a), 4);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            req_valid  = 1'($urandom_range(0, 1));
            req_wr     = 1'($urandom_range(0, 1));
            req_burst  = ($urandom % 8) == 0;
            req_addr   = 16'($urandom_range(0, 127));
            req_wdata  = 16'($urandom);
            resp_ready = ($urandom % 4) != 0;
            cyc();
        end
        drain();
        chk("final_busy", 64'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
